divider: RTL and testbench

//  Multi-cycle unsigned restoring divider: the inverse of the 16x16 multiplier.

---
 rtl/divider_if.sv | 31 +++
 rtl/divider.sv | 123 ++++++++++++
 tb/tb_divider.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : divider_if
//  Description : Request/result bundle for the multi-cycle unsigned divider.
//  Revision    : 1.0
// ============================================================================
interface divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividendHi;
  logic [WIDTH-1:0] dividendLo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic             overflow;

  modport master (
    output start, dividendHi, dividendLo, divisor,
    input  quotient, remainder, busy, done, divByZero, overflow
  );

  modport slave (
    input  start, dividendHi, dividendLo, divisor,
    output quotient, remainder, busy, done, divByZero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Restoring divider, {hi,lo} / divisor, one quotient bit per clock.
//  Revision    : 1.0
// ============================================================================
module divider #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  bus
);
  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_div;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_divbyzero;
  logic               r_overflow;

  logic [WIDTH+1:0]   w_s;
  logic [WIDTH+1:0]   w_diff;
  logic               w_borrow;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_q_nxt;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    w_s       = {r_rem, r_q[WIDTH-1]};
    w_diff    = w_s - {2'b00, r_div};
    w_borrow  = w_diff[WIDTH+1];
    w_rem_nxt = w_borrow ? w_s[WIDTH:0] : w_diff[WIDTH:0];
    w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0 || bus.dividendHi >= bus.divisor) w_state_nxt = S_DONE;
          else                                                    w_state_nxt = S_RUN;
        end
      end
      S_RUN:   if (r_cnt == c_cnt_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divbyzero <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_div       <= bus.divisor;
            r_divbyzero <= 1'b0;
            r_overflow  <= 1'b0;
            if (bus.divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividendLo;
              r_divbyzero <= 1'b1;
            end else if (bus.dividendHi >= bus.divisor) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividendHi;
              r_overflow  <= 1'b1;
            end else begin
              r_rem <= {1'b0, bus.dividendHi};
              r_q   <= bus.dividendLo;
              r_cnt <= c_cnt_init;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - c_cnt_last;
          if (r_cnt == c_cnt_last) begin
            r_quotient  <= w_q_nxt;
            r_remainder <= w_rem_nxt[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.divByZero = r_divbyzero;
  assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider
//  Description : Directed self-checking bench for the restoring divider.
//  Revision    : 1.0
// ============================================================================
module tb_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  divider_if #(.WIDTH(16)) bus ();

  divider #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] dv);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dividendHi = hi;
    bus.dividendLo = lo;
    bus.divisor    = dv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // lat = edges after the accepting edge until done is seen; busy_n = busy samples.
  task automatic wait_done(output int lat, output int busy_n, output bit seen);
    lat = 0; busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input logic [15:0] hi, input logic [15:0] lo,
                          input logic [15:0] dv, input logic [15:0] exp_q,
                          input logic [15:0] exp_r, input logic exp_dz, input logic exp_ov);
    int lat, busy_n;
    bit seen;
    issue(hi, lo, dv);
    wait_done(lat, busy_n, seen);
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_q"}, 32'(bus.quotient), 32'(exp_q));
    check({tag, "_r"}, 32'(bus.remainder), 32'(exp_r));
    check({tag, "_flags"}, {30'd0, bus.divByZero, bus.overflow}, {30'd0, exp_dz, exp_ov});
    if (exp_dz || exp_ov) begin
      check({tag, "_lat_short"}, 32'(lat <= 1), 32'd1);
      check({tag, "_busy"}, 32'(busy_n), 32'd0);
    end else begin
      check({tag, "_lat"}, 32'(lat), 32'd16);
      check({tag, "_busy"}, 32'(busy_n), 32'd16);
    end
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold_q"}, 32'(bus.quotient), 32'(exp_q));
  endtask

  initial begin
    int lat, busy_n, dones;
    bit seen;
    bus.start = 1'b0; bus.dividendHi = '0; bus.dividendLo = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
    check("rst_ctl", {28'd0, bus.busy, bus.done, bus.divByZero, bus.overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_case("basic",  16'h0001, 16'h86A0, 16'd300,  16'h014D, 16'd100, 1'b0, 1'b0);
    run_case("dz",     16'h1234, 16'h5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0);
    run_case("ovf",    16'h0005, 16'h0000, 16'h0005, 16'hFFFF, 16'h0005, 1'b0, 1'b1);
    run_case("max",    16'hFFFE, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run_case("small",  16'h0000, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 1'b0, 1'b0);
    run_case("ff",     16'h0000, 16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 1'b0, 1'b0);

    // Start during RUN must be ignored and must not create a second done.
    issue(16'h0000, 16'd1000, 16'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividendLo = 16'd9; bus.divisor = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("ign_dones", 32'(dones), 32'd1);
    check("ign_q", 32'(bus.quotient), 32'd100);
    check("ign_r", 32'(bus.remainder), 32'd0);

    // Asynchronous reset mid-RUN clears outputs without a done pulse.
    issue(16'h0000, 16'd1000, 16'd10);
    repeat (7) @(posedge clk);
    #2;
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_q", 32'(bus.quotient), 32'd0);
    check("abort_ctl", {28'd0, bus.busy, bus.done, bus.divByZero, bus.overflow}, 32'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort_nodone", 32'(dones), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_case("post",   16'h0000, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
